// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM controller: state enum,
// ALU operation codes, instruction field encodings and the condition check.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_EOR = 4'b0100;
   localparam logic [3:0] ALU_MOV = 4'b0101;
   localparam logic [3:0] ALU_LSL = 4'b0110;
   localparam logic [3:0] ALU_LSR = 4'b0111;
   localparam logic [3:0] ALU_ASR = 4'b1000;
   localparam logic [3:0] ALU_ROR = 4'b1001;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      {n, z, c, v} = nzcv;
      res = 1'b0;
      case (cond)
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         COND_AL: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Data-processing decode: {aluop, funct, sh} -> ALU operation and raw flag-write
// mask (flagw[1] = NZ, flagw[0] = CV), before condition gating.
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic       aluop,
   input  logic [5:0] funct,
   input  logic [1:0] sh,
   output logic [3:0] alucontrol,
   output logic [1:0] flagw
);

   logic wr_nz, wr_cv;

   always_comb begin
      alucontrol = ALU_ADD;
      wr_nz      = 1'b0;
      wr_cv      = 1'b0;
      if (aluop) begin
         case (funct[4:1])
            CMD_ADD: begin alucontrol = ALU_ADD; wr_nz = 1'b1; wr_cv = 1'b1; end
            CMD_SUB,
            CMD_CMP: begin alucontrol = ALU_SUB; wr_nz = 1'b1; wr_cv = 1'b1; end
            CMD_AND,
            CMD_TST: begin alucontrol = ALU_AND; wr_nz = 1'b1; end
            CMD_ORR: begin alucontrol = ALU_ORR; wr_nz = 1'b1; end
            CMD_EOR: begin alucontrol = ALU_EOR; wr_nz = 1'b1; end
            CMD_MOV: begin
               wr_nz = 1'b1;
               // An immediate operand has no shift field; it moves straight through.
               if (funct[5]) alucontrol = ALU_MOV;
               else begin
                  case (sh)
                     2'b00:   alucontrol = ALU_LSL;
                     2'b01:   alucontrol = ALU_LSR;
                     2'b10:   alucontrol = ALU_ASR;
                     default: alucontrol = ALU_ROR;
                  endcase
               end
            end
            default: alucontrol = ALU_ADD;
         endcase
      end
   end

   assign flagw = funct[0] ? {wr_nz, wr_cv} : 2'b00;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARMv4 controller: FSM, NZCV register, condition latch and datapath
// controls. Define MC_MEM_WAIT_EN to add the MemReady stall input.
module mc_control_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [1:0] sh,
   input  logic [3:0] ALUFlags,
`ifdef MC_MEM_WAIT_EN
   input  logic       MemReady,
`endif
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUControl,
   output logic [3:0] state_dbg
);

   state_t     state, next;
   logic [3:0] flags;
   logic       condex;
   logic       regw, memw, pcs, irw, fetch, aluop;
   logic [1:0] flagw;
   logic       mem_ok;

   // Memory handshake: a FETCH/MEMRD/MEMWR access completes in the cycle
   // MemReady is high; until then the state holds and its writes stay low.
`ifdef MC_MEM_WAIT_EN
   assign mem_ok = MemReady;
`else
   assign mem_ok = 1'b1;
`endif

   mc_alu_decode u_alu_decode (
      .aluop      (aluop),
      .funct      (Funct),
      .sh         (sh),
      .alucontrol (ALUControl),
      .flagw      (flagw)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         flags  <= 4'b0000;
         condex <= 1'b0;
      end else begin
         state <= next;
         if (state == DECODE) condex <= cond_check(Cond, flags);
         if (flagw[1] && condex) flags[3:2] <= ALUFlags[3:2];
         if (flagw[0] && condex) flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_comb begin
      next      = state;
      regw      = 1'b0;
      memw      = 1'b0;
      pcs       = 1'b0;
      irw       = 1'b0;
      fetch     = 1'b0;
      aluop     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (state)
         FETCH: begin
            irw = 1'b1; fetch = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            if (mem_ok) next = DECODE;
         end
         DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            case (Op)
               OP_MEM:  next = MEMADR;
               OP_DP:   next = Funct[5] ? EXECI : EXECR;
               OP_BR:   next = BRANCH;
               default: next = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            next    = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            if (mem_ok) next = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01; regw = 1'b1; next = FETCH;
         end
         MEMWR: begin
            AdrSrc = 1'b1; memw = 1'b1;
            if (mem_ok) next = FETCH;
         end
         EXECR, EXECI: begin
            aluop   = 1'b1;
            ALUSrcB = (state == EXECI) ? 2'b01 : 2'b00;
            next    = (Funct[4:1] == CMD_TST || Funct[4:1] == CMD_CMP) ? FETCH : ALUWB;
         end
         ALUWB: begin
            regw = 1'b1; next = FETCH;
         end
         BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; pcs = 1'b1; next = FETCH;
         end
         default: next = FETCH;
      endcase
      if (regw && Rd == 4'd15) pcs = 1'b1;
   end

   // Reset gating keeps the FETCH-state enables low while reset is held.
   assign RegWrite  = regw & condex;
   assign MemWrite  = memw & condex & mem_ok;
   assign PCWrite   = ~reset & ((fetch & mem_ok) | (pcs & condex));
   assign IRWrite   = ~reset & irw & mem_ok;
   assign ImmSrc    = Op;
   assign RegSrc    = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
   assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: hand-computed expectations checked with
// immediate assertions; covers the MemReady stall when MC_MEM_WAIT_EN is set.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Cond = 4'b1110;
   logic [1:0] Op = 2'b01;
   logic [5:0] Funct = 6'b000000;
   logic [3:0] Rd = 4'd2;
   logic [1:0] sh = 2'b00;
   logic [3:0] ALUFlags = 4'b0000;
`ifdef MC_MEM_WAIT_EN
   logic       MemReady = 1'b1;
`endif
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0] ALUControl, state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                          S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                          S_ALUWB = 4'd8, S_BRANCH = 4'd9;

   mc_control_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .sh         (sh),
      .ALUFlags   (ALUFlags),
`ifdef MC_MEM_WAIT_EN
      .MemReady   (MemReady),
`endif
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ResultSrc  (ResultSrc),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_branch(input logic [3:0] cond, input logic exp_pc, input string tag);
      Cond = cond; Op = 2'b10; Funct = 6'b101000; Rd = 4'd0; ALUFlags = 4'b0000;
      check({tag, "_fetch"}, state_dbg, S_FETCH);
      tick;
      check({tag, "_decode"}, state_dbg, S_DECODE);
      check({tag, "_immsrc"}, {2'b00, ImmSrc}, 4'b0010);
      check({tag, "_regsrc"}, {2'b00, RegSrc}, 4'b0001);
      tick;
      check({tag, "_branch"}, state_dbg, S_BRANCH);
      check({tag, "_pcwrite"}, {3'b000, PCWrite}, {3'b000, exp_pc});
      check({tag, "_srcb"}, {2'b00, ALUSrcB}, 4'b0001);
      tick;
      check({tag, "_done"}, state_dbg, S_FETCH);
   endtask

   task automatic do_dp(input logic [3:0] cond, input logic [5:0] funct, input logic [3:0] rd,
                        input logic [1:0] shv, input logic [3:0] aflags, input logic [3:0] exp_alu,
                        input logic wb, input logic exp_rw, input string tag);
      Cond = cond; Op = 2'b00; Funct = funct; Rd = rd; sh = shv; ALUFlags = aflags;
      check({tag, "_fetch"}, state_dbg, S_FETCH);
      tick;
      check({tag, "_decode"}, state_dbg, S_DECODE);
      tick;
      check({tag, "_exec"}, state_dbg, funct[5] ? S_EXECI : S_EXECR);
      check({tag, "_alu"}, ALUControl, exp_alu);
      check({tag, "_srcb"}, {2'b00, ALUSrcB}, funct[5] ? 4'b0001 : 4'b0000);
      check({tag, "_exec_rw"}, {3'b000, RegWrite}, 4'b0000);
      tick;
      if (wb) begin
         check({tag, "_aluwb"}, state_dbg, S_ALUWB);
         check({tag, "_regwrite"}, {3'b000, RegWrite}, {3'b000, exp_rw});
         check({tag, "_wb_pc"}, {3'b000, PCWrite}, {3'b000, exp_rw && rd == 4'd15});
         tick;
      end
      check({tag, "_done"}, state_dbg, S_FETCH);
   endtask

   task automatic do_mem(input logic [3:0] cond, input logic l, input logic [3:0] rd,
                         input logic exp_w, input string tag);
      Cond = cond; Op = 2'b01; Funct = {5'b11000, l}; Rd = rd; ALUFlags = 4'b0000;
      check({tag, "_fetch"}, state_dbg, S_FETCH);
      tick;
      check({tag, "_decode"}, state_dbg, S_DECODE);
      tick;
      check({tag, "_memadr"}, state_dbg, S_MEMADR);
      check({tag, "_regsrc"}, {2'b00, RegSrc}, {2'b00, ~l, 1'b0});
      tick;
      if (l) begin
         check({tag, "_memrd"}, state_dbg, S_MEMRD);
         check({tag, "_adrsrc"}, {3'b000, AdrSrc}, 4'b0001);
         tick;
         check({tag, "_memwb"}, state_dbg, S_MEMWB);
         check({tag, "_resultsrc"}, {2'b00, ResultSrc}, 4'b0001);
         check({tag, "_regwrite"}, {3'b000, RegWrite}, {3'b000, exp_w});
         check({tag, "_pcwrite"}, {3'b000, PCWrite}, {3'b000, exp_w && rd == 4'd15});
      end else begin
         check({tag, "_memwr"}, state_dbg, S_MEMWR);
         check({tag, "_memwrite"}, {3'b000, MemWrite}, {3'b000, exp_w});
      end
      tick;
      check({tag, "_done"}, state_dbg, S_FETCH);
   endtask

   initial begin
      // Reset held: FETCH with every write enable low.
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state_dbg, S_FETCH);
      check("rst_pcwrite", {3'b000, PCWrite}, 4'b0000);
      check("rst_irwrite", {3'b000, IRWrite}, 4'b0000);
      check("rst_memwrite", {3'b000, MemWrite}, 4'b0000);
      reset = 1'b0;
      #1;
      check("fetch_pcwrite", {3'b000, PCWrite}, 4'b0001);
      check("fetch_irwrite", {3'b000, IRWrite}, 4'b0001);
      check("fetch_srca", {3'b000, ALUSrcA}, 4'b0001);
      check("fetch_srcb", {2'b00, ALUSrcB}, 4'b0010);
      check("fetch_result", {2'b00, ResultSrc}, 4'b0010);

      // STR interrupted by reset in MEMWR.
      tick;
      check("str_decode", state_dbg, S_DECODE);
      tick;
      check("str_memadr", state_dbg, S_MEMADR);
      tick;
      check("str_memwr", state_dbg, S_MEMWR);
      check("str_memwrite", {3'b000, MemWrite}, 4'b0001);
      reset = 1'b1;
      #1;
      check("midrst_memwrite", {3'b000, MemWrite}, 4'b0000);
      check("midrst_state", state_dbg, S_FETCH);
      check("midrst_pcwrite", {3'b000, PCWrite}, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;

      // Flags are 0000 after reset: EQ fails, CC passes.
      do_branch(4'b0000, 1'b0, "beq_rst");
      do_branch(4'b0011, 1'b1, "bcc_rst");

      // ADDS R1 with ALU NZCV=0110.
      do_dp(4'b1110, 6'b001001, 4'd1, 2'b00, 4'b0110, 4'b0000, 1'b1, 1'b1, "adds");
      do_branch(4'b0000, 1'b1, "beq_adds");
      do_branch(4'b0010, 1'b1, "bcs_adds");
      do_branch(4'b0100, 1'b0, "bmi_adds");
      do_branch(4'b0110, 1'b0, "bvs_adds");

      // CMP then BEQ, Z=1 and Z=0.
      do_dp(4'b1110, 6'b010101, 4'd0, 2'b00, 4'b0100, 4'b0001, 1'b0, 1'b0, "cmp_z1");
      do_branch(4'b0000, 1'b1, "beq_z1");
      do_dp(4'b1110, 6'b010101, 4'd0, 2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0, "cmp_z0");
      do_branch(4'b0000, 1'b0, "beq_z0");

      // LDR R15: five cycles, writeback loads PC.
      do_mem(4'b1110, 1'b1, 4'd15, 1'b1, "ldr_pc");

      // STRNE with Z=1 suppresses MemWrite.
      do_dp(4'b1110, 6'b010101, 4'd0, 2'b00, 4'b0100, 4'b0001, 1'b0, 1'b0, "cmp_setz");
      do_mem(4'b0001, 1'b0, 4'd3, 1'b0, "strne");

      // Set C,V then MOVS ASR: only NZ change (flags become 1011).
      do_dp(4'b1110, 6'b010101, 4'd0, 2'b00, 4'b0011, 4'b0001, 1'b0, 1'b0, "cmp_setcv");
      do_dp(4'b1110, 6'b011011, 4'd4, 2'b10, 4'b1000, 4'b1000, 1'b1, 1'b1, "movs_asr");
      do_branch(4'b0010, 1'b1, "bcs_mov");
      do_branch(4'b0110, 1'b1, "bvs_mov");
      do_branch(4'b0100, 1'b1, "bmi_mov");
      do_branch(4'b0000, 1'b0, "beq_mov");

      // ADDEQS fails its condition: no writeback and no flag update.
      do_dp(4'b0000, 6'b001001, 4'd5, 2'b00, 4'b0100, 4'b0000, 1'b1, 1'b0, "addeq_fail");
      do_branch(4'b0000, 1'b0, "beq_after_fail");

      // Immediate ORR, register LSR, EOR, ADD to R15, NOP, never-condition.
      do_dp(4'b1110, 6'b111000, 4'd6, 2'b00, 4'b0000, 4'b0011, 1'b1, 1'b1, "orr_imm");
      do_dp(4'b1110, 6'b011010, 4'd7, 2'b01, 4'b0000, 4'b0111, 1'b1, 1'b1, "lsr_reg");
      do_dp(4'b1110, 6'b000010, 4'd8, 2'b00, 4'b0000, 4'b0100, 1'b1, 1'b1, "eor_reg");
      do_dp(4'b1110, 6'b001000, 4'd15, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b1, "add_pc");
      Op = 2'b11; Cond = 4'b1110;
      tick;
      check("nop_decode", state_dbg, S_DECODE);
      tick;
      check("nop_done", state_dbg, S_FETCH);
      do_branch(4'b1111, 1'b0, "bnv");

`ifdef MC_MEM_WAIT_EN
      // FETCH stalls for three cycles on MemReady low.
      Op = 2'b11; MemReady = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("wait_state", state_dbg, S_FETCH);
         check("wait_irwrite", {3'b000, IRWrite}, 4'b0000);
         check("wait_pcwrite", {3'b000, PCWrite}, 4'b0000);
         tick;
      end
      MemReady = 1'b1;
      #1;
      check("ready_irwrite", {3'b000, IRWrite}, 4'b0001);
      check("ready_pcwrite", {3'b000, PCWrite}, 4'b0001);
      tick;
      check("ready_decode", state_dbg, S_DECODE);
      tick;
      check("ready_done", state_dbg, S_FETCH);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
